onewire_tconv: RTL and testbench

Temperature-conversion sequencer sitting directly downstream of `onewire_adapter`. It consumes the adapter's ConvertT request (`owam_convert`) and returns the finished 16-bit reading (`owam_temp`) and the done strobe (`owam_ctok`). It times the conversion window per the configured resolution, powers and handshakes the temperature ADC, and formats the raw sample. It also drives busy status and the parasite-power strong-pullup enable.

---
 rtl/onewire_tconv.sv | 149 ++++++++++++++
 tb/tb_onewire_tconv.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/onewire_tconv.sv
// Temperature-conversion sequencer: times the ConvertT window for the selected
// resolution, powers and handshakes the ADC, and formats the captured sample.
module onewire_tconv #(
    parameter int unsigned TCONV9 = 28125,
    parameter int unsigned SETTLE = 300
) (
    input  logic        clk_300,
    input  logic        owpo_rst,
    input  logic        owam_convert,
    input  logic [7:0]  owam_cfg,
    input  logic        owam_ppm,
    input  logic        adc_ack,
    input  logic [11:0] adc_data,
    output logic        adc_en,
    output logic        adc_req,
    output logic [15:0] owam_temp,
    output logic        owam_ctok,
    output logic        owam_busy,
    output logic        owam_spu,
    output logic        owam_cterr
);

    localparam int unsigned CW = 18;
    localparam logic [CW-1:0] TCONV_W  = CW'(TCONV9);
    localparam logic [CW-1:0] SETTLE_W = CW'(SETTLE);
    localparam logic [15:0]   TEMP_POR = 16'h0550;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  elapsed_q, elapsed_d;
    logic [CW-1:0]  last_q, last_d;
    logic [1:0]     res_q, res_d;
    logic           captured_q, captured_d;
    logic [11:0]    sample_q, sample_d;
    logic           adc_en_d, adc_req_d, ctok_d, busy_d, cterr_d;
    logic [15:0]    temp_d;

    // Only the resolution field of the config register matters here.
    logic unused_cfg;
    assign unused_cfg = ^{owam_cfg[7], owam_cfg[4:0]};

    // Sign-extend and clear the LSBs below the selected resolution.
    function automatic logic [15:0] fmt_temp(input logic [11:0] s, input logic [1:0] r);
        logic [15:0] ext;
        ext = {{4{s[11]}}, s};
        case (r)
            2'b00:   fmt_temp = ext & 16'hFFF8;
            2'b01:   fmt_temp = ext & 16'hFFFC;
            2'b10:   fmt_temp = ext & 16'hFFFE;
            default: fmt_temp = ext;
        endcase
    endfunction

    always_ff @(posedge clk_300 or posedge owpo_rst) begin
        if (owpo_rst) begin
            state_q    <= IDLE;
            elapsed_q  <= '0;
            last_q     <= '0;
            res_q      <= 2'b00;
            captured_q <= 1'b0;
            sample_q   <= '0;
            adc_en     <= 1'b0;
            adc_req    <= 1'b0;
            owam_temp  <= TEMP_POR;
            owam_ctok  <= 1'b0;
            owam_busy  <= 1'b0;
            owam_spu   <= 1'b0;
            owam_cterr <= 1'b0;
        end else begin
            state_q    <= state_d;
            elapsed_q  <= elapsed_d;
            last_q     <= last_d;
            res_q      <= res_d;
            captured_q <= captured_d;
            sample_q   <= sample_d;
            adc_en     <= adc_en_d;
            adc_req    <= adc_req_d;
            owam_temp  <= temp_d;
            owam_ctok  <= ctok_d;
            owam_busy  <= busy_d;
            owam_spu   <= owam_busy & owam_ppm;
            owam_cterr <= cterr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        elapsed_d  = elapsed_q;
        last_d     = last_q;
        res_d      = res_q;
        captured_d = captured_q;
        sample_d   = sample_q;
        adc_en_d   = adc_en;
        adc_req_d  = adc_req;
        temp_d     = owam_temp;
        ctok_d     = 1'b0;
        busy_d     = owam_busy;
        cterr_d    = owam_cterr;

        case (state_q)
            IDLE: begin
                if (owam_convert) begin
                    state_d    = CONV;
                    res_d      = owam_cfg[6:5];
                    last_d     = (TCONV_W << owam_cfg[6:5]) - CW'(1);
                    elapsed_d  = '0;
                    captured_d = 1'b0;
                    cterr_d    = 1'b0;
                    adc_en_d   = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            CONV: begin
                elapsed_d = elapsed_q + CW'(1);
                if (elapsed_q + CW'(1) == SETTLE_W) begin
                    adc_req_d = 1'b1;
                end
                // First ack while requesting wins, including on the final window cycle.
                if (adc_ack && adc_req && !captured_q) begin
                    sample_d   = adc_data;
                    captured_d = 1'b1;
                    adc_req_d  = 1'b0;
                end
                if (elapsed_q == last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d   = IDLE;
                ctok_d    = 1'b1;
                busy_d    = 1'b0;
                adc_en_d  = 1'b0;
                adc_req_d = 1'b0;
                if (captured_q) begin
                    temp_d = fmt_temp(sample_q, res_q);
                end else begin
                    cterr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_onewire_tconv.sv
// Directed bench for onewire_tconv with a short conversion window.
module tb_onewire_tconv;

    localparam int unsigned TCONV9 = 40;
    localparam int unsigned SETTLE = 8;

    logic        clk_300 = 1'b0;
    logic        owpo_rst;
    logic        owam_convert;
    logic [7:0]  owam_cfg;
    logic        owam_ppm;
    logic        adc_ack;
    logic [11:0] adc_data;
    logic        adc_en;
    logic        adc_req;
    logic [15:0] owam_temp;
    logic        owam_ctok;
    logic        owam_busy;
    logic        owam_spu;
    logic        owam_cterr;

    int n_checks = 0;
    int n_fail   = 0;

    onewire_tconv #(.TCONV9(TCONV9), .SETTLE(SETTLE)) dut (
        .clk_300     (clk_300),
        .owpo_rst    (owpo_rst),
        .owam_convert(owam_convert),
        .owam_cfg    (owam_cfg),
        .owam_ppm    (owam_ppm),
        .adc_ack     (adc_ack),
        .adc_data    (adc_data),
        .adc_en      (adc_en),
        .adc_req     (adc_req),
        .owam_temp   (owam_temp),
        .owam_ctok   (owam_ctok),
        .owam_busy   (owam_busy),
        .owam_spu    (owam_spu),
        .owam_cterr  (owam_cterr)
    );

    always #5 clk_300 = ~clk_300;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion from the current negedge; t counts negedges after the convert edge.
    task automatic run_conv(input string tag, input logic [7:0] cfg, input bit do_ack,
                            input int ack_dly, input logic [11:0] data, input int extra_t,
                            input int exp_lat, output int spu_cnt);
        int t;
        int req_t;
        int lat;
        t = 0; req_t = -1; lat = -1; spu_cnt = 0;
        owam_cfg = cfg;
        adc_data = data;
        owam_convert = 1'b1;
        @(negedge clk_300);
        check({tag, " busy"}, 32'(owam_busy), 32'd1);
        check({tag, " adc_en"}, 32'(adc_en), 32'd1);
        check({tag, " spu_t0"}, 32'(owam_spu), 32'd0);
        while (lat < 0 && t < exp_lat + 20) begin
            owam_convert = (t == extra_t);
            if (t == extra_t) owam_cfg = 8'h60;
            adc_ack = do_ack && req_t >= 0 && t == req_t + ack_dly;
            @(negedge clk_300);
            t++;
            if (adc_req && req_t < 0) req_t = t;
            if (owam_spu) spu_cnt++;
            if (owam_ctok) lat = t;
        end
        owam_convert = 1'b0;
        adc_ack = 1'b0;
        check({tag, " req_rise"}, 32'(req_t), 32'(SETTLE));
        check({tag, " ctok_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy_done"}, 32'(owam_busy), 32'd0);
        check({tag, " adc_en_done"}, 32'(adc_en), 32'd0);
    endtask

    initial begin
        int spu_cnt;
        int ctok_cnt;
        owpo_rst = 1'b1;
        owam_convert = 1'b0;
        owam_cfg = 8'h00;
        owam_ppm = 1'b0;
        adc_ack = 1'b0;
        adc_data = 12'h000;
        repeat (3) @(negedge clk_300);
        owpo_rst = 1'b0;
        @(negedge clk_300);

        check("rst temp", 32'(owam_temp), 32'h0550);
        check("rst busy", 32'(owam_busy), 32'd0);
        check("rst adc_en", 32'(adc_en), 32'd0);
        check("rst adc_req", 32'(adc_req), 32'd0);
        check("rst ctok", 32'(owam_ctok), 32'd0);
        check("rst spu", 32'(owam_spu), 32'd0);
        check("rst cterr", 32'(owam_cterr), 32'd0);

        // No ack: ctok still pulses, temp holds power-on value, cterr set.
        run_conv("noack", 8'h00, 1'b0, 0, 12'h123, -1, 41, spu_cnt);
        check("noack temp", 32'(owam_temp), 32'h0550);
        check("noack cterr", 32'(owam_cterr), 32'd1);
        check("noack spu_cnt", 32'(spu_cnt), 32'd0);

        // 12-bit, parasite power, ack 3 cycles after req.
        owam_ppm = 1'b1;
        run_conv("r12", 8'h60, 1'b1, 3, 12'h191, -1, 321, spu_cnt);
        check("r12 temp", 32'(owam_temp), 32'h0191);
        check("r12 cterr", 32'(owam_cterr), 32'd0);
        check("r12 spu_cnt", 32'(spu_cnt), 32'd321);
        check("r12 spu_lag", 32'(owam_spu), 32'd1);
        @(negedge clk_300);
        check("r12 ctok_once", 32'(owam_ctok), 32'd0);
        check("r12 spu_off", 32'(owam_spu), 32'd0);
        owam_ppm = 1'b0;

        run_conv("r9neg", 8'h00, 1'b1, 2, 12'hE6F, -1, 41, spu_cnt);
        check("r9neg temp", 32'(owam_temp), 32'hFE68);
        check("r9neg spu_cnt", 32'(spu_cnt), 32'd0);

        run_conv("r10", 8'h20, 1'b1, 5, 12'h191, -1, 81, spu_cnt);
        check("r10 temp", 32'(owam_temp), 32'h0190);

        // Mid-window convert + cfg change ignored; ack on final window cycle captured.
        run_conv("ign", 8'h00, 1'b1, 39 - SETTLE, 12'h7D5, 15, 41, spu_cnt);
        check("ign temp", 32'(owam_temp), 32'h07D0);
        check("ign cterr", 32'(owam_cterr), 32'd0);
        ctok_cnt = 0;
        repeat (50) begin
            @(negedge clk_300);
            if (owam_ctok) ctok_cnt++;
        end
        check("ign no_2nd_ctok", 32'(ctok_cnt), 32'd0);

        // Reset mid-conversion aborts immediately.
        owam_ppm = 1'b1;
        owam_cfg = 8'h60;
        owam_convert = 1'b1;
        @(negedge clk_300);
        owam_convert = 1'b0;
        repeat (20) @(negedge clk_300);
        check("prerst busy", 32'(owam_busy), 32'd1);
        check("prerst req", 32'(adc_req), 32'd1);
        check("prerst spu", 32'(owam_spu), 32'd1);
        #2 owpo_rst = 1'b1;
        #1;
        check("midrst busy", 32'(owam_busy), 32'd0);
        check("midrst adc_en", 32'(adc_en), 32'd0);
        check("midrst req", 32'(adc_req), 32'd0);
        check("midrst spu", 32'(owam_spu), 32'd0);
        check("midrst temp", 32'(owam_temp), 32'h0550);
        @(negedge clk_300);
        owpo_rst = 1'b0;
        owam_ppm = 1'b0;
        ctok_cnt = 0;
        repeat (400) begin
            @(negedge clk_300);
            if (owam_ctok) ctok_cnt++;
        end
        check("midrst no_ctok", 32'(ctok_cnt), 32'd0);

        run_conv("r11", 8'h40, 1'b1, 1, 12'h191, -1, 161, spu_cnt);
        check("r11 temp", 32'(owam_temp), 32'h0190);
        check("r11 cterr", 32'(owam_cterr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
